// File: rtl/chisq_sched.sv
// Round-robin scheduler sharing one chisq_unit between NREQ lanes, with a lane/tag pipeline matched to unit latency.
// Optional CHISQ_SCHED_CUT_EN builds the res_pass <= chi_cut comparator; otherwise res_pass marks every result.
module chisq_sched #(
  parameter int unsigned NREQ          = 4,
  parameter int unsigned PARAMETERBITS = 14,
  parameter int unsigned CHISQBITS     = 32,
  parameter int unsigned TAGBITS       = 8,
  parameter int unsigned ISSUE_GAP     = 3,
  parameter int unsigned LATENCY       = 8
) (
  input  logic                            clock,
  input  logic                            reset,
  input  logic [NREQ-1:0]                 req_valid,
  output logic [NREQ-1:0]                 req_ready,
  input  logic [NREQ*PARAMETERBITS-1:0]   req_chi1,
  input  logic [NREQ*PARAMETERBITS-1:0]   req_chi2,
  input  logic [NREQ*PARAMETERBITS-1:0]   req_chi3,
  input  logic [NREQ*TAGBITS-1:0]         req_tag,
  input  logic [CHISQBITS-1:0]            chi_cut,
  output logic [PARAMETERBITS-1:0]        unit_chi1,
  output logic [PARAMETERBITS-1:0]        unit_chi2,
  output logic [PARAMETERBITS-1:0]        unit_chi3,
  output logic                            unit_dv,
  input  logic [CHISQBITS-1:0]            unit_chisq,
  output logic                            res_valid,
  output logic [$clog2(NREQ)-1:0]         res_src,
  output logic [TAGBITS-1:0]              res_tag,
  output logic [CHISQBITS-1:0]            res_chisq,
  output logic                            res_pass,
  output logic                            busy
);

  localparam int unsigned SW = $clog2(NREQ);
  localparam int unsigned CW = (ISSUE_GAP > 1) ? $clog2(ISSUE_GAP) : 1;

  typedef enum logic {GAP_READY, GAP_WAIT} gap_state_t;

  gap_state_t             gap_state;
  logic [CW-1:0]          gap_cnt;
  logic [SW-1:0]          ptr;
  logic                   grant_any;
  logic [SW-1:0]          grant_idx;
  logic [SW-1:0]          cand;
  logic [SW-1:0]          next_ptr;
  logic [LATENCY-1:0]     pipe_v;
  logic [SW-1:0]          pipe_src [LATENCY];
  logic [TAGBITS-1:0]     pipe_tag [LATENCY];

  // First valid lane at or after ptr, searched upward modulo NREQ.
  always_comb begin
    grant_any = 1'b0;
    grant_idx = '0;
    cand      = '0;
    req_ready = '0;
    if (!reset && gap_state == GAP_READY) begin
      for (int unsigned k = 0; k < NREQ; k++) begin
        cand = SW'((32'(ptr) + k) % NREQ);
        if (!grant_any && req_valid[cand]) begin
          grant_any = 1'b1;
          grant_idx = cand;
        end
      end
    end
    if (grant_any) req_ready[grant_idx] = 1'b1;
  end

  assign next_ptr = (grant_idx == SW'(NREQ - 1)) ? '0 : grant_idx + 1'b1;
  assign busy     = (gap_state == GAP_WAIT) || (|pipe_v);

  always_ff @(posedge clock) begin
    if (reset) begin
      gap_state <= GAP_READY;
      gap_cnt   <= '0;
      ptr       <= '0;
      unit_dv   <= 1'b0;
      unit_chi1 <= '0;
      unit_chi2 <= '0;
      unit_chi3 <= '0;
      pipe_v    <= '0;
      res_valid <= 1'b0;
      res_src   <= '0;
      res_tag   <= '0;
      res_chisq <= '0;
      res_pass  <= 1'b0;
    end else begin
      unit_dv <= grant_any;
      if (grant_any) begin
        unit_chi1 <= req_chi1[grant_idx*PARAMETERBITS +: PARAMETERBITS];
        unit_chi2 <= req_chi2[grant_idx*PARAMETERBITS +: PARAMETERBITS];
        unit_chi3 <= req_chi3[grant_idx*PARAMETERBITS +: PARAMETERBITS];
        ptr       <= next_ptr;
      end

      case (gap_state)
        GAP_READY: begin
          if (grant_any && ISSUE_GAP > 1) begin
            gap_cnt   <= CW'(ISSUE_GAP - 1);
            gap_state <= GAP_WAIT;
          end
        end
        GAP_WAIT: begin
          gap_cnt <= gap_cnt - 1'b1;
          if (gap_cnt == CW'(1)) gap_state <= GAP_READY;
        end
        default: gap_state <= GAP_READY;
      endcase

      // LATENCY shift stages plus the result register; unit_chisq is sampled the cycle before res_valid.
      pipe_v[0]   <= grant_any;
      pipe_src[0] <= grant_idx;
      pipe_tag[0] <= req_tag[grant_idx*TAGBITS +: TAGBITS];
      for (int unsigned i = 1; i < LATENCY; i++) begin
        pipe_v[i]   <= pipe_v[i-1];
        pipe_src[i] <= pipe_src[i-1];
        pipe_tag[i] <= pipe_tag[i-1];
      end

      res_valid <= pipe_v[LATENCY-1];
      if (pipe_v[LATENCY-1]) begin
        res_src   <= pipe_src[LATENCY-1];
        res_tag   <= pipe_tag[LATENCY-1];
        res_chisq <= unit_chisq;
      end
`ifdef CHISQ_SCHED_CUT_EN
      res_pass <= pipe_v[LATENCY-1] && (unit_chisq <= chi_cut);
`else
      res_pass <= pipe_v[LATENCY-1];
`endif
    end
  end

`ifndef CHISQ_SCHED_CUT_EN
  logic unused_cut;
  assign unused_cut = ^chi_cut;
`endif

endmodule

// File: tb/tb_chisq_sched.sv
// Scoreboard bench for chisq_sched: a cycle-level arbitration model plus an in-order expected-result queue.
// A behavioural chisq_unit stub (sum of squares, all-ones when chi1 is all-ones) closes the loop.
module tb_chisq_sched;

  localparam int NREQ = 4;
  localparam int PB   = 14;
  localparam int CB   = 32;
  localparam int TB   = 8;
  localparam int GAP  = 3;
  localparam int LAT  = 8;

  logic                  clock = 1'b0;
  logic                  reset;
  logic [NREQ-1:0]       req_valid;
  logic [NREQ-1:0]       req_ready;
  logic [NREQ*PB-1:0]    req_chi1, req_chi2, req_chi3;
  logic [NREQ*TB-1:0]    req_tag;
  logic [CB-1:0]         chi_cut;
  logic [PB-1:0]         unit_chi1, unit_chi2, unit_chi3;
  logic                  unit_dv;
  logic [CB-1:0]         unit_chisq;
  logic                  res_valid;
  logic [$clog2(NREQ)-1:0] res_src;
  logic [TB-1:0]         res_tag;
  logic [CB-1:0]         res_chisq;
  logic                  res_pass;
  logic                  busy;

  chisq_sched #(
    .NREQ(NREQ), .PARAMETERBITS(PB), .CHISQBITS(CB), .TAGBITS(TB),
    .ISSUE_GAP(GAP), .LATENCY(LAT)
  ) dut (
    .clock(clock), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_chi1(req_chi1), .req_chi2(req_chi2), .req_chi3(req_chi3),
    .req_tag(req_tag), .chi_cut(chi_cut),
    .unit_chi1(unit_chi1), .unit_chi2(unit_chi2), .unit_chi3(unit_chi3),
    .unit_dv(unit_dv), .unit_chisq(unit_chisq),
    .res_valid(res_valid), .res_src(res_src), .res_tag(res_tag),
    .res_chisq(res_chisq), .res_pass(res_pass), .busy(busy)
  );

  always #5 clock = ~clock;

  longint cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  function automatic logic [CB-1:0] unit_fn(input logic [PB-1:0] a, input logic [PB-1:0] b,
                                            input logic [PB-1:0] c);
    if (a == '1) return '1;
    return 32'(a) * 32'(a) + 32'(b) * 32'(b) + 32'(c) * 32'(c);
  endfunction

  // chisq_unit stub: result for a dv issued in cycle D is presented in cycle D+LAT-1.
  logic [CB-1:0] ush [LAT-1];
  always @(posedge clock) begin
    ush[0] <= unit_dv ? unit_fn(unit_chi1, unit_chi2, unit_chi3) : 32'hDEAD_BEEF;
    for (int i = 1; i < LAT - 1; i++) ush[i] <= ush[i-1];
  end
  assign unit_chisq = ush[LAT-2];

  typedef struct {
    logic [PB-1:0] a, b, c;
    logic [TB-1:0] t;
  } req_t;

  typedef struct {
    int            src;
    logic [TB-1:0] tag;
    logic [CB-1:0] chisq;
    logic          pass;
    longint        issue;
    longint        due;
  } exp_t;

  req_t lq [NREQ][$];
  exp_t sb [$];

  function automatic bit lanes_pending();
    for (int i = 0; i < NREQ; i++) if (lq[i].size() > 0) return 1'b1;
    return 1'b0;
  endfunction

  task automatic apply_lanes();
    for (int i = 0; i < NREQ; i++) begin
      if (lq[i].size() > 0) begin
        req_valid[i]         = 1'b1;
        req_chi1[i*PB +: PB] = lq[i][0].a;
        req_chi2[i*PB +: PB] = lq[i][0].b;
        req_chi3[i*PB +: PB] = lq[i][0].c;
        req_tag[i*TB +: TB]  = lq[i][0].t;
      end else begin
        req_valid[i] = 1'b0;
      end
    end
  endtask

  task automatic push_req(input int l, input logic [PB-1:0] a, input logic [PB-1:0] b,
                          input logic [PB-1:0] c, input logic [TB-1:0] t);
    req_t r;
    r.a = a; r.b = b; r.c = c; r.t = t;
    lq[l].push_back(r);
  endtask

  task automatic step();
    logic [NREQ-1:0] grab;
    @(negedge clock);
    grab = req_valid & req_ready;
    @(posedge clock);
    #1;
    for (int i = 0; i < NREQ; i++) if (grab[i]) void'(lq[i].pop_front());
    apply_lanes();
  endtask

  task automatic wait_idle(input int limit);
    int n = 0;
    while ((lanes_pending() || sb.size() != 0 || busy) && n < limit) begin
      step();
      n++;
    end
    checks++;
    if (n >= limit) begin
      errors++;
      $display("FAIL wait_idle: still busy after %0d cycles, expected idle", n);
    end
  endtask

  // Checker: reference arbitration from the rules, result scoreboard, unit-side strobes.
  longint        last_g = -1000;
  int            ptr_m = 0;
  bit            prev_reset = 1'b0;
  bit            exp_dv = 1'b0;
  logic [PB-1:0] exp_c1, exp_c2, exp_c3;

  initial begin
    forever begin
      int              exp_g;
      logic [NREQ-1:0] exp_ready;
      bit              exp_busy;
      bit              exp_res;
      exp_t            e;
      @(negedge clock);
      if (reset) begin
        if (prev_reset) begin
          chk("rst_req_ready", req_ready, '0);
          chk("rst_busy", busy, 0);
          chk("rst_unit_dv", unit_dv, 0);
          chk("rst_res_valid", res_valid, 0);
        end
        last_g = -1000;
        ptr_m  = 0;
        exp_dv = 1'b0;
        sb.delete();
      end else begin
        exp_g = -1;
        if (cyc - last_g >= GAP) begin
          for (int k = 0; k < NREQ; k++)
            if (exp_g < 0 && req_valid[(ptr_m + k) % NREQ]) exp_g = (ptr_m + k) % NREQ;
        end
        exp_ready = '0;
        if (exp_g >= 0) exp_ready[exp_g] = 1'b1;
        chk("req_ready", req_ready, exp_ready);

        exp_busy = (cyc - last_g < GAP);
        foreach (sb[j]) if (sb[j].issue < cyc && cyc < sb[j].due) exp_busy = 1'b1;
        chk("busy", busy, exp_busy);

        chk("unit_dv", unit_dv, exp_dv);
        if (exp_dv) begin
          chk("unit_chi1", unit_chi1, exp_c1);
          chk("unit_chi2", unit_chi2, exp_c2);
          chk("unit_chi3", unit_chi3, exp_c3);
        end

        exp_res = (sb.size() > 0) && (sb[0].due == cyc);
        chk("res_valid", res_valid, exp_res);
        if (exp_res) begin
          e = sb.pop_front();
          if (res_valid) begin
            chk("res_src", res_src, e.src);
            chk("res_tag", res_tag, e.tag);
            chk("res_chisq", res_chisq, e.chisq);
            chk("res_pass", res_pass, e.pass);
          end
        end else begin
          chk("res_pass_idle", res_pass, 0);
        end

        exp_dv = 1'b0;
        if (exp_g >= 0) begin
          exp_c1   = req_chi1[exp_g*PB +: PB];
          exp_c2   = req_chi2[exp_g*PB +: PB];
          exp_c3   = req_chi3[exp_g*PB +: PB];
          e.src    = exp_g;
          e.tag    = req_tag[exp_g*TB +: TB];
          e.chisq  = unit_fn(exp_c1, exp_c2, exp_c3);
`ifdef CHISQ_SCHED_CUT_EN
          e.pass   = (e.chisq <= chi_cut);
`else
          e.pass   = 1'b1;
`endif
          e.issue  = cyc;
          e.due    = cyc + 1 + LAT;
          sb.push_back(e);
          last_g = cyc;
          ptr_m  = (exp_g + 1) % NREQ;
          exp_dv = 1'b1;
        end
      end
      prev_reset = reset;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    reset     = 1'b1;
    req_valid = '0;
    req_chi1  = '0;
    req_chi2  = '0;
    req_chi3  = '0;
    req_tag   = '0;
    chi_cut   = 32'd100;
    repeat (3) step();
    reset = 1'b0;
    chk("rst_res_src", res_src, 0);
    chk("rst_res_tag", res_tag, 0);
    chk("rst_res_chisq", res_chisq, 0);
    chk("rst_unit_chi1", unit_chi1, 0);

    // All four lanes at once from ptr 0: grants 0,1,2,3 three cycles apart.
    for (int l = 0; l < NREQ; l++) push_req(l, 14'(10 + l), 14'(20 + l), 14'(30 + l), 8'(8'h40 + l));
    apply_lanes();
    wait_idle(200);

    // Single request (3,4,5) -> 50.
    push_req(0, 14'd3, 14'd4, 14'd5, 8'h11);
    apply_lanes();
    wait_idle(200);

    // Lane 2 streaming alone.
    for (int k = 0; k < 5; k++) push_req(2, 14'($urandom), 14'($urandom), 14'($urandom), 8'(8'hA0 + k));
    apply_lanes();
    wait_idle(300);

    // Cut boundary: exactly at cut, one above, saturated.
    chi_cut = 32'd100;
    push_req(0, 14'd10, 14'd0, 14'd0, 8'h01);
    push_req(0, 14'd10, 14'd1, 14'd0, 8'h02);
    push_req(0, 14'h3FFF, 14'd5, 14'd5, 8'h03);
    apply_lanes();
    wait_idle(300);
    chi_cut = '1;
    push_req(1, 14'h3FFF, 14'd0, 14'd0, 8'h04);
    apply_lanes();
    wait_idle(200);

    // Reset with two results in flight; nothing may emerge, then an immediate grant.
    push_req(0, 14'd7, 14'd7, 14'd7, 8'h21);
    push_req(1, 14'd8, 14'd8, 14'd8, 8'h22);
    apply_lanes();
    repeat (8) step();
    reset = 1'b1;
    repeat (2) step();
    reset = 1'b0;
    chk("busy_after_reset", busy, 0);
    step();
    push_req(2, 14'd1, 14'd2, 14'd3, 8'h23);
    apply_lanes();
    wait_idle(200);

    // Lane 1 withdraws during the gap; lane 3 arrives and takes the next slot.
    push_req(0, 14'd11, 14'd12, 14'd13, 8'h31);
    push_req(1, 14'd14, 14'd15, 14'd16, 8'h32);
    apply_lanes();
    step();
    lq[1].delete();
    push_req(3, 14'd17, 14'd18, 14'd19, 8'h33);
    apply_lanes();
    wait_idle(200);

    // Randomized traffic with a mid-range cut.
    chi_cut = 32'd150_000_000;
    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(0, 2) == 0) begin
        int l;
        l = int'($urandom_range(0, NREQ - 1));
        if (lq[l].size() < 3)
          push_req(l, ($urandom_range(0, 15) == 0) ? 14'h3FFF : 14'($urandom),
                   14'($urandom), 14'($urandom), 8'($urandom));
        apply_lanes();
      end
      step();
    end
    wait_idle(500);
    repeat (3) step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
